// File: rtl/blackjack_round_fsm.sv
// Blackjack round controller: deals cards from a Galois LFSR or an injection port, tracks both
// hands with soft-ace totals and plays the dealer. Define BJ_DEALER_HITS_SOFT17_EN to hit soft 17.
module blackjack_round_fsm #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       hit_pressed,
    input  logic       stand_pressed,
    input  logic       deal_pressed,
    input  logic       card_inject_valid,
    input  logic [3:0] card_inject_rank,
    output logic [4:0] player_total,
    output logic [4:0] dealer_total,
    output logic [3:0] player_count,
    output logic [3:0] dealer_count,
    output logic [3:0] last_card,
    output logic       last_to_dealer,
    output logic       card_strobe,
    output logic       hole_hidden,
    output logic [2:0] state,
    output logic [1:0] outcome,
    output logic       round_done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DEAL   = 3'd1,
        S_PLAY   = 3'd2,
        S_HIT    = 3'd3,
        S_DEALER = 3'd4,
        S_RESULT = 3'd5
    } state_t;

    localparam logic [15:0] SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [4:0]  p_hard_q, p_hard_d, d_hard_q, d_hard_d;
    logic        p_ace_q, p_ace_d, d_ace_q, d_ace_d;
    logic [3:0]  p_cnt_q, p_cnt_d, d_cnt_q, d_cnt_d;
    logic [3:0]  last_card_q, last_card_d;
    logic        last_to_dealer_q, last_to_dealer_d;
    logic        card_strobe_q, card_strobe_d;
    logic        hole_hidden_q, hole_hidden_d;
    logic [1:0]  outcome_q, outcome_d;
    logic        round_done_q, round_done_d;
    logic [2:0]  deal_cnt_q, deal_cnt_d;
    logic        hit_drawn_q, hit_drawn_d;

    logic [4:0]  p_best, d_best;
    logic [3:0]  lfsr_rank, draw_rank;
    logic [4:0]  draw_val;
    logic        draw_ok, want_card, to_dealer, dealer_wants;

    function automatic logic [4:0] best_total(input logic [4:0] hard, input logic ace);
        return (ace && hard <= 5'd11) ? hard + 5'd10 : hard;
    endfunction

    function automatic logic [1:0] judge(input logic [4:0] pb, input logic [4:0] db);
        if (pb > 5'd21)      return 2'b10;
        else if (db > 5'd21) return 2'b01;
        else if (pb > db)    return 2'b01;
        else if (pb < db)    return 2'b10;
        else                 return 2'b11;
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] c);
        return (c == 4'd15) ? c : c + 4'd1;
    endfunction

    assign p_best    = best_total(p_hard_q, p_ace_q);
    assign d_best    = best_total(d_hard_q, d_ace_q);
    assign lfsr_rank = lfsr_q[3:0];

`ifdef BJ_DEALER_HITS_SOFT17_EN
    assign dealer_wants = (d_best < 5'd17) || (d_best == 5'd17 && d_ace_q && d_hard_q == 5'd7);
`else
    assign dealer_wants = (d_best < 5'd17);
`endif

    // Injected ranks always win and are clamped; LFSR candidates outside 1..13 retry next cycle.
    always_comb begin
        if (card_inject_valid) begin
            draw_rank = (card_inject_rank == 4'd0 || card_inject_rank > 4'd13) ? 4'd13
                                                                               : card_inject_rank;
            draw_ok   = 1'b1;
        end else begin
            draw_rank = lfsr_rank;
            draw_ok   = (lfsr_rank != 4'd0) && (lfsr_rank <= 4'd13);
        end
        draw_val = (draw_rank >= 4'd10) ? 5'd10 : {1'b0, draw_rank};
    end

    // Request inputs are single-cycle pulses with no ready: a pulse is acted on only in a state
    // that accepts it and is otherwise dropped, never queued.
    always_comb begin
        state_d          = state_q;
        lfsr_d           = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
        p_hard_d         = p_hard_q;
        p_ace_d          = p_ace_q;
        p_cnt_d          = p_cnt_q;
        d_hard_d         = d_hard_q;
        d_ace_d          = d_ace_q;
        d_cnt_d          = d_cnt_q;
        last_card_d      = last_card_q;
        last_to_dealer_d = last_to_dealer_q;
        card_strobe_d    = 1'b0;
        hole_hidden_d    = hole_hidden_q;
        outcome_d        = outcome_q;
        deal_cnt_d       = deal_cnt_q;
        hit_drawn_d      = hit_drawn_q;
        want_card        = 1'b0;
        to_dealer        = 1'b0;

        case (state_q)
            S_IDLE, S_RESULT: begin
                if (deal_pressed) begin
                    state_d       = S_DEAL;
                    p_hard_d      = 5'd0;
                    p_ace_d       = 1'b0;
                    p_cnt_d       = 4'd0;
                    d_hard_d      = 5'd0;
                    d_ace_d       = 1'b0;
                    d_cnt_d       = 4'd0;
                    hole_hidden_d = 1'b1;
                    outcome_d     = 2'b00;
                    deal_cnt_d    = 3'd0;
                end
            end
            S_DEAL: begin
                if (deal_cnt_q < 3'd4) begin
                    want_card = 1'b1;
                    to_dealer = deal_cnt_q[0];
                end else if (p_best == 5'd21) begin
                    state_d       = S_DEALER;
                    hole_hidden_d = 1'b0;
                end else begin
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (stand_pressed) begin
                    state_d       = S_DEALER;
                    hole_hidden_d = 1'b0;
                end else if (hit_pressed) begin
                    state_d     = S_HIT;
                    hit_drawn_d = 1'b0;
                end
            end
            S_HIT: begin
                if (!hit_drawn_q) begin
                    want_card = 1'b1;
                end else if (p_best > 5'd21) begin
                    state_d   = S_RESULT;
                    outcome_d = 2'b10;
                end else if (p_best == 5'd21) begin
                    state_d       = S_DEALER;
                    hole_hidden_d = 1'b0;
                end else begin
                    state_d = S_PLAY;
                end
            end
            S_DEALER: begin
                if (dealer_wants) begin
                    want_card = 1'b1;
                    to_dealer = 1'b1;
                end else begin
                    state_d   = S_RESULT;
                    outcome_d = judge(p_best, d_best);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (want_card && draw_ok) begin
            card_strobe_d    = 1'b1;
            last_card_d      = draw_rank;
            last_to_dealer_d = to_dealer;
            if (to_dealer) begin
                d_hard_d = d_hard_q + draw_val;
                d_ace_d  = d_ace_q | (draw_rank == 4'd1);
                d_cnt_d  = sat_inc(d_cnt_q);
            end else begin
                p_hard_d = p_hard_q + draw_val;
                p_ace_d  = p_ace_q | (draw_rank == 4'd1);
                p_cnt_d  = sat_inc(p_cnt_q);
            end
            if (state_q == S_DEAL) deal_cnt_d = deal_cnt_q + 3'd1;
            if (state_q == S_HIT)  hit_drawn_d = 1'b1;
        end

        round_done_d = (state_d == S_RESULT);
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q          <= S_IDLE;
            lfsr_q           <= SEED_EFF;
            p_hard_q         <= 5'd0;
            p_ace_q          <= 1'b0;
            p_cnt_q          <= 4'd0;
            d_hard_q         <= 5'd0;
            d_ace_q          <= 1'b0;
            d_cnt_q          <= 4'd0;
            last_card_q      <= 4'd0;
            last_to_dealer_q <= 1'b0;
            card_strobe_q    <= 1'b0;
            hole_hidden_q    <= 1'b0;
            outcome_q        <= 2'b00;
            round_done_q     <= 1'b0;
            deal_cnt_q       <= 3'd0;
            hit_drawn_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            lfsr_q           <= lfsr_d;
            p_hard_q         <= p_hard_d;
            p_ace_q          <= p_ace_d;
            p_cnt_q          <= p_cnt_d;
            d_hard_q         <= d_hard_d;
            d_ace_q          <= d_ace_d;
            d_cnt_q          <= d_cnt_d;
            last_card_q      <= last_card_d;
            last_to_dealer_q <= last_to_dealer_d;
            card_strobe_q    <= card_strobe_d;
            hole_hidden_q    <= hole_hidden_d;
            outcome_q        <= outcome_d;
            round_done_q     <= round_done_d;
            deal_cnt_q       <= deal_cnt_d;
            hit_drawn_q      <= hit_drawn_d;
        end
    end

    assign player_total   = p_best;
    assign dealer_total   = d_best;
    assign player_count   = p_cnt_q;
    assign dealer_count   = d_cnt_q;
    assign last_card      = last_card_q;
    assign last_to_dealer = last_to_dealer_q;
    assign card_strobe    = card_strobe_q;
    assign hole_hidden    = hole_hidden_q;
    assign state          = state_q;
    assign outcome        = outcome_q;
    assign round_done     = round_done_q;

endmodule

// File: tb/tb_blackjack_round_fsm.sv
// Bench for blackjack_round_fsm: a table of directed rounds, hand-written corner sequences and
// random rounds whose expectations come from a queue-of-ranks card-game model.
`timescale 1ns/1ps
module tb_blackjack_round_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hit = 1'b0, stand = 1'b0, deal = 1'b0;
    logic       inj_v = 1'b0;
    logic [3:0] inj_r = 4'd0;
    logic [4:0] player_total, dealer_total;
    logic [3:0] player_count, dealer_count, last_card;
    logic       last_to_dealer, card_strobe, hole_hidden, round_done;
    logic [2:0] state;
    logic [1:0] outcome;

    int n_checks = 0;
    int n_err = 0;

    blackjack_round_fsm dut (
        .CLOCK_50          (clk),
        .reset             (rst_n),
        .hit_pressed       (hit),
        .stand_pressed     (stand),
        .deal_pressed      (deal),
        .card_inject_valid (inj_v),
        .card_inject_rank  (inj_r),
        .player_total      (player_total),
        .dealer_total      (dealer_total),
        .player_count      (player_count),
        .dealer_count      (dealer_count),
        .last_card         (last_card),
        .last_to_dealer    (last_to_dealer),
        .card_strobe       (card_strobe),
        .hole_hidden       (hole_hidden),
        .state             (state),
        .outcome           (outcome),
        .round_done        (round_done)
    );

    always #10 clk = ~clk;

    // One directed or random round. Ranks are nibbles, first card in the top nibble
    // (1 = ace, A..D hex = 10/J/Q/K). Deal order is player, dealer, player, dealer.
    typedef struct {
        logic [15:0] deal;
        logic [15:0] hits;
        int          nhits;
        logic [31:0] feed;
        logic [4:0]  e_pt;
        logic [4:0]  e_dt;
        logic [3:0]  e_pc;
        logic [3:0]  e_dc;
        logic [1:0]  e_out;
        logic        e_hole;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int nib16(input logic [15:0] v, input int k);
        return int'(v[15-4*k -: 4]);
    endfunction

    function automatic int nib32(input logic [31:0] v, input int k);
        return int'(v[31-4*k -: 4]);
    endfunction

    // ---------------- card-game reference model ----------------
    function automatic int clamp_rank(input int r);
        return (r < 1 || r > 13) ? 13 : r;
    endfunction

    function automatic int card_val(input int r);
        return (r >= 10) ? 10 : r;
    endfunction

    function automatic int hard_of(input int q[$]);
        int s = 0;
        foreach (q[i]) s += card_val(q[i]);
        return s;
    endfunction

    function automatic bit has_ace(input int q[$]);
        foreach (q[i]) if (q[i] == 1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int best_of(input int q[$]);
        int h = hard_of(q);
        if (has_ace(q) && h <= 11) return h + 10;
        return h;
    endfunction

    function automatic bit dealer_draws(input int q[$]);
        int b = best_of(q);
`ifdef BJ_DEALER_HITS_SOFT17_EN
        return (b < 17) || (b == 17 && has_ace(q) && hard_of(q) == 7);
`else
        return b < 17;
`endif
    endfunction

    task automatic model_round(inout vec_t v);
        int  pq[$];
        int  dq[$];
        int  pb, db, k;
        bit  in_play;
        pq.push_back(clamp_rank(nib16(v.deal, 0)));
        dq.push_back(clamp_rank(nib16(v.deal, 1)));
        pq.push_back(clamp_rank(nib16(v.deal, 2)));
        dq.push_back(clamp_rank(nib16(v.deal, 3)));
        in_play = (best_of(pq) != 21);
        for (int h = 0; h < v.nhits; h++) begin
            if (in_play) begin
                pq.push_back(clamp_rank(nib16(v.hits, h)));
                in_play = (best_of(pq) < 21);
            end
        end
        pb = best_of(pq);
        if (pb <= 21) begin
            k = 0;
            while (dealer_draws(dq) && k < 8) begin
                dq.push_back(clamp_rank(nib32(v.feed, k)));
                k++;
            end
        end
        db = best_of(dq);
        v.e_pt   = 5'(pb);
        v.e_dt   = 5'(db);
        v.e_pc   = 4'(pq.size());
        v.e_dc   = 4'(dq.size());
        v.e_hole = (pb > 21);
        if (pb > 21)      v.e_out = 2'b10;
        else if (db > 21) v.e_out = 2'b01;
        else if (pb > db) v.e_out = 2'b01;
        else if (pb < db) v.e_out = 2'b10;
        else              v.e_out = 2'b11;
    endtask

    // ---------------- drivers ----------------
    task automatic do_deal(input logic [15:0] d, input string tag);
        inj_v = 1'b1;
        inj_r = d[15:12];
        deal  = 1'b1;
        tick();
        deal = 1'b0;
        chk({tag, ".enter_deal"}, int'(state), 1);
        chk({tag, ".deal_no_strobe"}, int'(card_strobe), 0);
        for (int k = 0; k < 4; k++) begin
            inj_r = 4'(nib16(d, k));
            tick();
            chk({tag, ".deal_strobe"}, int'(card_strobe), 1);
            chk({tag, ".deal_rank"}, int'(last_card), clamp_rank(nib16(d, k)));
            chk({tag, ".deal_to_dealer"}, int'(last_to_dealer), k % 2);
        end
    endtask

    task automatic run_round(input vec_t v, input string tag);
        int pq[$];
        int pb;
        bit in_play;
        do_deal(v.deal, tag);
        tick();
        pq.push_back(clamp_rank(nib16(v.deal, 0)));
        pq.push_back(clamp_rank(nib16(v.deal, 2)));
        in_play = (best_of(pq) != 21);
        chk({tag, ".post_deal_state"}, int'(state), in_play ? 2 : 4);
        chk({tag, ".post_deal_hole"}, int'(hole_hidden), in_play ? 1 : 0);
        chk({tag, ".post_deal_strobe"}, int'(card_strobe), 0);
        for (int h = 0; h < v.nhits; h++) begin
            if (in_play) begin
                hit = 1'b1;
                tick();
                hit = 1'b0;
                chk({tag, ".hit_state"}, int'(state), 3);
                inj_r = 4'(nib16(v.hits, h));
                tick();
                chk({tag, ".hit_strobe"}, int'(card_strobe), 1);
                chk({tag, ".hit_rank"}, int'(last_card), clamp_rank(nib16(v.hits, h)));
                chk({tag, ".hit_to_dealer"}, int'(last_to_dealer), 0);
                tick();
                pq.push_back(clamp_rank(nib16(v.hits, h)));
                pb = best_of(pq);
                chk({tag, ".after_hit_state"}, int'(state), (pb > 21) ? 5 : (pb == 21) ? 4 : 2);
                in_play = (pb < 21);
            end
        end
        pb = best_of(pq);
        if (in_play) begin
            stand = 1'b1;
            tick();
            stand = 1'b0;
            chk({tag, ".stand_state"}, int'(state), 4);
            chk({tag, ".stand_hole"}, int'(hole_hidden), 0);
        end
        if (pb <= 21) begin
            for (int k = 0; k < 12; k++) begin
                inj_r = (k < 8) ? 4'(nib32(v.feed, k)) : 4'd1;
                tick();
                if (round_done) break;
            end
        end
        chk({tag, ".round_done"}, int'(round_done), 1);
        chk({tag, ".state_result"}, int'(state), 5);
        chk({tag, ".player_total"}, int'(player_total), int'(v.e_pt));
        chk({tag, ".dealer_total"}, int'(dealer_total), int'(v.e_dt));
        chk({tag, ".player_count"}, int'(player_count), int'(v.e_pc));
        chk({tag, ".dealer_count"}, int'(dealer_count), int'(v.e_dc));
        chk({tag, ".outcome"}, int'(outcome), int'(v.e_out));
        chk({tag, ".hole_hidden"}, int'(hole_hidden), int'(v.e_hole));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".state"}, int'(state), 0);
        chk({tag, ".player_total"}, int'(player_total), 0);
        chk({tag, ".dealer_total"}, int'(dealer_total), 0);
        chk({tag, ".player_count"}, int'(player_count), 0);
        chk({tag, ".dealer_count"}, int'(dealer_count), 0);
        chk({tag, ".last_card"}, int'(last_card), 0);
        chk({tag, ".last_to_dealer"}, int'(last_to_dealer), 0);
        chk({tag, ".card_strobe"}, int'(card_strobe), 0);
        chk({tag, ".hole_hidden"}, int'(hole_hidden), 0);
        chk({tag, ".outcome"}, int'(outcome), 0);
        chk({tag, ".round_done"}, int'(round_done), 0);
    endtask

    initial begin
        vec_t v;
        int   strobes;

        tbl[0]  = '{deal:16'hA978, hits:16'h0000, nhits:0, feed:32'h0,
                    e_pt:5'd17, e_dt:5'd17, e_pc:4'd2, e_dc:4'd2, e_out:2'b11, e_hole:1'b0};
        tbl[1]  = '{deal:16'hA562, hits:16'hD000, nhits:1, feed:32'h0,
                    e_pt:5'd26, e_dt:5'd7,  e_pc:4'd3, e_dc:4'd2, e_out:2'b10, e_hole:1'b1};
        tbl[2]  = '{deal:16'h1967, hits:16'h9000, nhits:1, feed:32'h5000_0000,
                    e_pt:5'd16, e_dt:5'd21, e_pc:4'd3, e_dc:4'd3, e_out:2'b10, e_hole:1'b0};
        tbl[3]  = '{deal:16'h1AD6, hits:16'h0000, nhits:0, feed:32'h6000_0000,
                    e_pt:5'd21, e_dt:5'd22, e_pc:4'd2, e_dc:4'd3, e_out:2'b01, e_hole:1'b0};
        tbl[4]  = '{deal:16'h0FE7, hits:16'h0000, nhits:0, feed:32'h0,
                    e_pt:5'd20, e_dt:5'd17, e_pc:4'd2, e_dc:4'd2, e_out:2'b01, e_hole:1'b0};
        tbl[5]  = '{deal:16'h9283, hits:16'h0000, nhits:0, feed:32'h2310_0000,
                    e_pt:5'd17, e_dt:5'd21, e_pc:4'd2, e_dc:4'd5, e_out:2'b10, e_hole:1'b0};
        tbl[6]  = '{deal:16'h5A67, hits:16'hA000, nhits:1, feed:32'h0,
                    e_pt:5'd21, e_dt:5'd17, e_pc:4'd3, e_dc:4'd2, e_out:2'b01, e_hole:1'b0};
        tbl[7]  = '{deal:16'hA171, hits:16'h0000, nhits:0, feed:32'h4A30_0000,
                    e_pt:5'd17, e_dt:5'd19, e_pc:4'd2, e_dc:4'd5, e_out:2'b10, e_hole:1'b0};
`ifdef BJ_DEALER_HITS_SOFT17_EN
        tbl[8]  = '{deal:16'hA196, hits:16'h0000, nhits:0, feed:32'h5A00_0000,
                    e_pt:5'd19, e_dt:5'd22, e_pc:4'd2, e_dc:4'd4, e_out:2'b01, e_hole:1'b0};
`else
        tbl[8]  = '{deal:16'hA196, hits:16'h0000, nhits:0, feed:32'h5A00_0000,
                    e_pt:5'd19, e_dt:5'd17, e_pc:4'd2, e_dc:4'd2, e_out:2'b01, e_hole:1'b0};
`endif
        tbl[9]  = '{deal:16'hA6A4, hits:16'h0000, nhits:0, feed:32'hA000_0000,
                    e_pt:5'd20, e_dt:5'd20, e_pc:4'd2, e_dc:4'd3, e_out:2'b11, e_hole:1'b0};
        tbl[10] = '{deal:16'h2A37, hits:16'h4500, nhits:2, feed:32'h0,
                    e_pt:5'd14, e_dt:5'd17, e_pc:4'd4, e_dc:4'd2, e_out:2'b10, e_hole:1'b0};

        // Reset state
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Ignored inputs: hit in IDLE, deal in PLAY, hit+stand together means stand
        hit = 1'b1;
        tick();
        hit = 1'b0;
        chk("idle_hit.state", int'(state), 0);
        chk("idle_hit.strobe", int'(card_strobe), 0);
        do_deal(16'hA978, "ign");
        tick();
        chk("ign.play", int'(state), 2);
        chk("ign.soft_pt", int'(player_total), 17);
        chk("ign.soft_dt", int'(dealer_total), 17);
        deal = 1'b1;
        tick();
        deal = 1'b0;
        chk("ign.deal_in_play", int'(state), 2);
        chk("ign.deal_in_play_pc", int'(player_count), 2);
        hit   = 1'b1;
        stand = 1'b1;
        tick();
        hit   = 1'b0;
        stand = 1'b0;
        chk("ign.hit_and_stand", int'(state), 4);
        inj_r = 4'd2;
        tick();
        tick();
        chk("ign.done", int'(round_done), 1);
        chk("ign.push", int'(outcome), 3);
        chk("ign.dealer_count", int'(dealer_count), 2);

        // Reset asserted mid-deal clears everything within the cycle
        inj_v = 1'b1;
        inj_r = 4'd10;
        deal  = 1'b1;
        tick();
        deal = 1'b0;
        tick();
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("post_reset.strobe", int'(card_strobe), 0);
            chk("post_reset.state", int'(state), 0);
        end

        // LFSR-sourced round: every accepted rank lies in 1..13
        inj_v = 1'b0;
        deal  = 1'b1;
        tick();
        deal    = 1'b0;
        strobes = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (card_strobe) begin
                strobes++;
                chk("lfsr.rank_in_range", int'(last_card >= 4'd1 && last_card <= 4'd13), 1);
            end
            if (state != 3'd1) break;
        end
        chk("lfsr.deal_strobes", strobes, 4);
        chk("lfsr.player_count", int'(player_count), 2);
        chk("lfsr.dealer_count", int'(dealer_count), 2);
        if (state == 3'd2) begin
            stand = 1'b1;
            tick();
            stand = 1'b0;
        end
        for (int k = 0; k < 100; k++) begin
            if (round_done) break;
            tick();
        end
        chk("lfsr.round_done", int'(round_done), 1);
        chk("lfsr.outcome_set", int'(outcome != 2'b00), 1);

        // Directed table
        for (int i = 0; i < 11; i++) begin
            run_round(tbl[i], $sformatf("vec%0d", i));
        end

        // Random rounds against the model
        for (int i = 0; i < 40; i++) begin
            v.deal  = 16'($urandom);
            v.hits  = 16'($urandom);
            v.nhits = $urandom_range(0, 3);
            v.feed  = $urandom;
            model_round(v);
            run_round(v, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/blackjack_round_fsm.md
# blackjack_round_fsm

Round controller for the FPGA blackjack game. It consumes the one-cycle `hit_pressed` / `stand_pressed` / `deal_pressed` pulses from the PS/2 key decoder. It deals cards from an internal LFSR (or from an injection port for test), tracks player and dealer hands with soft-ace handling, and runs the dealer's draw. It publishes totals and the round outcome to the display logic.

## Interface
Parameters:
- `LFSR_SEED`, default 16'hACE1: LFSR reset value. A value of 0 is loaded as 16'h0001.

Ports:
- `CLOCK_50` in 1: system clock.
- `reset` in 1: one clock; reset is asynchronous and active-low.
- `hit_pressed` in 1: one-cycle hit request.
- `stand_pressed` in 1: one-cycle stand request.
- `deal_pressed` in 1: one-cycle new-round request.
- `card_inject_valid` in 1: while high, a draw uses `card_inject_rank` instead of the LFSR.
- `card_inject_rank` in 4: injected rank, 1..13.
- `player_total` out 5: player best total.
- `dealer_total` out 5: dealer best total.
- `player_count` out 4: player card count, saturates at 15.
- `dealer_count` out 4: dealer card count, saturates at 15.
- `last_card` out 4: rank of the most recent card.
- `last_to_dealer` out 1: most recent card went to the dealer.
- `card_strobe` out 1: one-cycle pulse per dealt card.
- `hole_hidden` out 1: dealer second card not yet revealed.
- `state` out 3: current FSM state encoding.
- `outcome` out 2: 00 none, 01 win, 10 lose, 11 push.
- `round_done` out 1: high in RESULT.

## Operation
- LFSR: 16-bit Galois, mask 16'hB400, steps every cycle.
- Draw acceptance:
  - LFSR candidate rank = `lfsr[3:0]`. Accept it only if in 1..13; otherwise retry next cycle.
  - Injected rank is always accepted. Values 0 and 14..15 are clamped to 13.
- Card value: A = 1, 2..10 face value, J/Q/K = 10.
- Each hand keeps a 5-bit hard sum and an `ace_seen` bit.
  - Best total = hard + 10 if `ace_seen` and hard ≤ 11; otherwise hard.
  - Maximum hard sum is 31, so 5 bits never wrap.
- States:
  - IDLE (0): no hand in play.
  - DEAL (1): deals four cards in order P, D, P, D, then goes to PLAY. If player best = 21, it goes to DEALER instead (natural, auto-stand).
  - PLAY (2):
    - `stand_pressed` → DEALER.
    - `hit_pressed` → HIT.
    - Stand wins if both arrive in the same cycle.
  - HIT (3): draws one player card. Then:
    - best > 21 → RESULT (lose, dealer turn skipped).
    - best = 21 → DEALER.
    - else → PLAY.
  - DEALER (4):
    - Entry clears `hole_hidden`.
    - Draws while dealer best < 17, then → RESULT.
  - RESULT (5): outcome is fixed.
    - Player bust → lose.
    - Else dealer bust → win.
    - Else compare totals: higher wins, equal = push.
- `deal_pressed` is honoured only in IDLE or RESULT. It clears both hands, sets `hole_hidden`, sets `outcome` to 00, and enters DEAL.
- Inputs arriving in any other state are ignored. They are not queued.

## Timing
- All outputs reset to 0 except `hole_hidden` = 0 and `state` = IDLE. The LFSR loads `LFSR_SEED`.
- Assertion of `reset` at any time aborts the round immediately. No state survives it.
- A draw accepted in cycle N updates totals, counts, `last_card` and `last_to_dealer` at edge N+1. `card_strobe` is high during cycle N+1.
- Deal latency with injection held valid:
  - `deal_pressed` at cycle N → DEAL at N+1.
  - Cards strobe at N+2..N+5.
  - PLAY (or DEALER) at N+6.
- Hit latency: `hit_pressed` in PLAY at cycle M → HIT at M+1 → card at M+2 → next state at M+3.
- Outcome and `round_done` become valid on the same edge the FSM enters RESULT.

## Configuration
- `BJ_DEALER_HITS_SOFT17_EN` defined: the dealer also draws on soft 17 (best = 17 with `ace_seen` and hard = 7).
- Undefined: the dealer stands on every 17.

## Test plan
- Reset/IDLE: reset low mid-DEAL → all outputs 0 and `state` = 0 within the same cycle; no `card_strobe` after release until a deal.
- Basic round, injected ranks 10, 9, 7, 8:
  - Deal gives player 17, dealer 17.
  - Stand → `outcome` = 11 (push); `dealer_count` = 2.
- Player bust: inject 10, 5, 6, 2, then hit with K.
  - `player_total` = 26 → RESULT with `outcome` = 10.
  - `dealer_count` stays 2; `hole_hidden` stays 1.
- Soft ace: inject A, 9, 6, 7 → `player_total` = 17. Hit with 9 → `player_total` = 16 (ace demoted), state PLAY.
- Dealer soft 17: inject 10, A, 9, 6.
  - Stand: with macro, dealer draws (injected 5 → 12, then 10 → 22 → `outcome` = 01).
  - Without macro: dealer stands at 17 → `outcome` = 01 (19 > 17).
- Ignored inputs:
  - `hit_pressed` in IDLE and `deal_pressed` in PLAY → no state change.
  - Hit and stand in the same cycle in PLAY → DEALER.
